// File: rtl/wb_arbiter.sv
// wb_arbiter: arbitrates four writeback requesters onto the single register-file write port
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   req_valid  per-requester write request (0 ALU, 1 dmem, 2 link, 3 imm/special)
//   req_data   packed write data, requester i at [i*WIDTH +: WIDTH]
//   req_reg    packed destination register, requester i at [i*REGW +: REGW]
//   rf_stall   register-file write port unavailable this cycle
//   req_ready  one-hot grant, combinational
//   wr_en, wr_reg, wr_data  registered register-file write
//   regsrc     one-hot source of the current write, 0 when idle
module wb_arbiter #(
    parameter int WIDTH    = 16,
    parameter int REGW     = 3,
    parameter int MAX_WAIT = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         req_valid,
    input  logic [4*WIDTH-1:0] req_data,
    input  logic [4*REGW-1:0]  req_reg,
    input  logic               rf_stall,
    output logic [3:0]         req_ready,
    output logic               wr_en,
    output logic [REGW-1:0]    wr_reg,
    output logic [WIDTH-1:0]   wr_data,
    output logic [3:0]         regsrc
);
    logic [3:0]       r_wait [4];
    logic [1:0]       r_rr_ptr;
    logic             r_wr_en;
    logic [REGW-1:0]  r_wr_reg;
    logic [WIDTH-1:0] r_wr_data;
    logic [3:0]       r_regsrc;
    logic [3:0]       w_grant;
    logic [1:0]       w_gidx;
    logic [1:0]       w_idx;
    logic             w_found;
    // starved requesters (lowest index first) pre-empt the round-robin scan
    always_comb begin
        w_grant = '0;
        w_gidx  = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int i = 0; i < 4; i++)
            if (!w_found && req_valid[i] && r_wait[i] == 4'(MAX_WAIT)) begin
                w_found = 1'b1;
                w_gidx  = 2'(i);
            end
        for (int k = 0; k < 4; k++) begin
            w_idx = r_rr_ptr + 2'(k);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_gidx  = w_idx;
            end
        end
        if (w_found && !rst && !rf_stall) w_grant[w_gidx] = 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_en   <= 1'b0;
            r_wr_reg  <= '0;
            r_wr_data <= '0;
            r_regsrc  <= '0;
            r_rr_ptr  <= '0;
            for (int i = 0; i < 4; i++) r_wait[i] <= '0;
        end else begin
            // a stalled write stays presented until the port frees up
            if (!rf_stall) begin
                r_wr_en  <= |w_grant;
                r_regsrc <= w_grant;
                if (|w_grant) begin
                    r_wr_reg  <= req_reg[w_gidx*REGW +: REGW];
                    r_wr_data <= req_data[w_gidx*WIDTH +: WIDTH];
                    r_rr_ptr  <= w_gidx + 2'd1;
                end
            end
            for (int i = 0; i < 4; i++)
                r_wait[i] <= (!req_valid[i] || w_grant[i]) ? 4'd0 :
                             (r_wait[i] >= 4'(MAX_WAIT)) ? 4'(MAX_WAIT) : r_wait[i] + 4'd1;
        end
    end
    assign req_ready = w_grant;
    assign wr_en     = r_wr_en;
    assign wr_reg    = r_wr_reg;
    assign wr_data   = r_wr_data;
    assign regsrc    = r_regsrc;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed self-checking bench for wb_arbiter (default and MAX_WAIT=2 instances)
module tb_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] d [4];
    logic [2:0]  r [4];
    logic [63:0] req_data;
    logic [11:0] req_reg;
    logic        rf_stall;
    logic [3:0]  req_ready, regsrc, req_ready2, regsrc2;
    logic        wr_en, wr_en2;
    logic [2:0]  wr_reg, wr_reg2;
    logic [15:0] wr_data, wr_data2;
    int          n_checks = 0;
    int          n_fail = 0;
    assign req_data = {d[3], d[2], d[1], d[0]};
    assign req_reg  = {r[3], r[2], r[1], r[0]};
    always #5 clk = ~clk;
    wb_arbiter dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_reg(req_reg),
        .rf_stall(rf_stall), .req_ready(req_ready), .wr_en(wr_en), .wr_reg(wr_reg),
        .wr_data(wr_data), .regsrc(regsrc)
    );
    wb_arbiter #(.MAX_WAIT(2)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_reg(req_reg),
        .rf_stall(rf_stall), .req_ready(req_ready2), .wr_en(wr_en2), .wr_reg(wr_reg2),
        .wr_data(wr_data2), .regsrc(regsrc2)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    initial begin
        rst = 1'b1;
        rf_stall = 1'b0;
        req_valid = 4'hF;
        d[0] = 16'h1000; d[1] = 16'h2001; d[2] = 16'h3002; d[3] = 16'h4003;
        r[0] = 3'd1; r[1] = 3'd2; r[2] = 3'd3; r[3] = 3'd4;
        tick;
        tick;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_wr_en", 32'(wr_en), 32'h0);
        chk("rst_regsrc", 32'(regsrc), 32'h0);
        chk("rst_wr_data", 32'(wr_data), 32'h0);
        chk("rst_wr_reg", 32'(wr_reg), 32'h0);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_ready", 32'(req_ready), 32'(4'b0001 << (k % 4)));
            tick;
            chk("rr_wr_en", 32'(wr_en), 32'h1);
            chk("rr_regsrc", 32'(regsrc), 32'(4'b0001 << (k % 4)));
            chk("rr_wr_data", 32'(wr_data), 32'(16'h1000 + 16'(k % 4) * 16'h1001));
        end
        req_valid = 4'b0010;
        d[1] = 16'hBEEF;
        r[1] = 3'd3;
        #1;
        chk("single_ready", 32'(req_ready), 32'h2);
        tick;
        chk("single_wr_en", 32'(wr_en), 32'h1);
        chk("single_wr_reg", 32'(wr_reg), 32'h3);
        chk("single_wr_data", 32'(wr_data), 32'hBEEF);
        chk("single_regsrc", 32'(regsrc), 32'h2);
        req_valid = 4'b0000;
        tick;
        chk("idle_wr_en", 32'(wr_en), 32'h0);
        chk("idle_regsrc", 32'(regsrc), 32'h0);
        chk("idle_hold_data", 32'(wr_data), 32'hBEEF);
        chk("idle_hold_reg", 32'(wr_reg), 32'h3);
        req_valid = 4'b0100;
        d[2] = 16'h1234;
        #1;
        chk("pre_stall_ready", 32'(req_ready), 32'h4);
        tick;
        chk("pre_stall_data", 32'(wr_data), 32'h1234);
        req_valid = 4'b0001;
        rf_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_ready", 32'(req_ready), 32'h0);
            tick;
            chk("stall_wr_en", 32'(wr_en), 32'h1);
            chk("stall_wr_data", 32'(wr_data), 32'h1234);
            chk("stall_regsrc", 32'(regsrc), 32'h4);
        end
        rf_stall = 1'b0;
        #1;
        chk("unstall_ready", 32'(req_ready), 32'h1);
        tick;
        chk("unstall_regsrc", 32'(regsrc), 32'h1);
        chk("unstall_wr_data", 32'(wr_data), 32'h1000);
        rst = 1'b1;
        req_valid = 4'hF;
        #1;
        chk("midrst_ready", 32'(req_ready), 32'h0);
        tick;
        chk("midrst_wr_en", 32'(wr_en), 32'h0);
        chk("midrst_regsrc", 32'(regsrc), 32'h0);
        rst = 1'b0;
        req_valid = 4'b0000;
        tick;
        chk("no_replay_wr_en", 32'(wr_en), 32'h0);
        req_valid = 4'hF;
        #1;
        chk("rrptr_reset_ready", 32'(req_ready), 32'h1);
        req_valid = 4'b1000;
        rf_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("starve_ready", 32'(req_ready), 32'h0);
            chk("starve_ready2", 32'(req_ready2), 32'h0);
            tick;
        end
        rf_stall = 1'b0;
        req_valid = 4'b1001;
        #1;
        chk("force_ready2", 32'(req_ready2), 32'h8);
        chk("noforce_ready", 32'(req_ready), 32'h1);
        tick;
        chk("force_regsrc2", 32'(regsrc2), 32'h8);
        chk("force_wr_data2", 32'(wr_data2), 32'h4003);
        chk("noforce_regsrc", 32'(regsrc), 32'h1);
        req_valid = 4'b0000;
        tick;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
